// File: rtl/gen_linear_combiner_pkg.sv
// Shared constants for the decomposed carry-lookahead adder.
// Defines the operand width, the packed non-linear term count, the per-group
// offset/size helpers and the combiner FSM state type. The non-linear term
// generator and the linear combiner both use these helpers, so they always
// agree on the term layout.
package gen_linear_combiner_pkg;

  localparam int unsigned NBIT = 4;
  localparam int unsigned NNL  = 2 ** (NBIT + 1) - 2 - NBIT;
  localparam int unsigned KW   = $clog2(NBIT);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Group g carries the terms of c(g+1).
  function automatic int unsigned grp_off(int unsigned g);
    return (2 ** (g + 1)) - 2 - g;
  endfunction

  function automatic int unsigned grp_size(int unsigned g);
    return (2 ** (g + 1)) - 1;
  endfunction

  // Bit mask covering n[grp_off(g) +: grp_size(g)].
  function automatic logic [NNL-1:0] grp_mask(int unsigned g);
    logic [NNL-1:0] m;
    int unsigned    lo;
    int unsigned    hi;
    lo = grp_off(g);
    hi = lo + grp_size(g);
    for (int unsigned i = 0; i < NNL; i++) begin
      m[i] = (i >= lo) && (i < hi);
    end
    return m;
  endfunction

endpackage

// File: rtl/gen_linear_combiner_if.sv
// Handshake bundle of the linear combiner.
// Input side : in_valid/in_ready with operands a, b and packed terms n.
// Output side: out_valid/out_ready with sum, cout and the self-check flag err.
// Modports: master (producer/consumer environment), slave (the combiner).
interface gen_linear_combiner_if;
  import gen_linear_combiner_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [NBIT-1:0] a;
  logic [NBIT-1:0] b;
  logic [NNL-1:0]  n;
  logic            out_valid;
  logic            out_ready;
  logic [NBIT-1:0] sum;
  logic            cout;
  logic            err;

  modport master (
    output in_valid, a, b, n, out_ready,
    input  in_ready, out_valid, sum, cout, err
  );

  modport slave (
    input  in_valid, a, b, n, out_ready,
    output in_ready, out_valid, sum, cout, err
  );

endinterface

// File: rtl/gen_group_parity.sv
// Combinational group parity: XOR of the non-linear terms of one carry group.
// Ports:
//   n      - packed non-linear terms
//   grp    - group index (0..NBIT-1)
//   parity - XOR of n[grp_off(grp) +: grp_size(grp)]
module gen_group_parity
  import gen_linear_combiner_pkg::*;
(
  input  logic [NNL-1:0] n,
  input  logic [KW-1:0]  grp,
  output logic           parity
);

  logic [NNL-1:0] mask;

  always_comb begin
    mask = '0;
    for (int unsigned g = 0; g < NBIT; g++) begin
      if (grp == KW'(g)) mask = grp_mask(g);
    end
    parity = ^(n & mask);
  end

endmodule

// File: rtl/gen_linear_combiner.sv
// Linear (XOR) half of the decomposed carry-lookahead adder.
// Captures a, b and the packed non-linear terms, then produces one sum bit per
// cycle LSB first, taking every carry from the term groups (no arithmetic
// carry path). Result is presented on a valid/ready output until consumed.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - gen_linear_combiner_if.slave handshake bundle
// Optional feature: define GEN_LINEAR_SELFCHECK_EN to compare {cout,sum}
// against a+b on completion and raise err on mismatch; otherwise err is 0.
module gen_linear_combiner
  import gen_linear_combiner_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  gen_linear_combiner_if.slave bus
);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [NBIT-1:0] a_q, b_q;
  logic [NNL-1:0]  n_q;
  logic [NBIT-1:0] sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            carry_q, carry_d;
  logic            accept;
  logic            finish;
  logic            grp_par;

  // Indexed by k: group k yields c(k+1), registered for the next bit; at the
  // last bit the same lookup (group NBIT-1) is the carry-out.
  gen_group_parity u_group_parity (
    .n      (n_q),
    .grp    (k_q),
    .parity (grp_par)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          k_d     = '0;
          carry_d = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[k_q] = a_q[k_q] ^ b_q[k_q] ^ carry_q;
        carry_d    = grp_par;
        k_d        = k_q + KW'(1);
        if (k_q == KW'(NBIT - 1)) begin
          cout_d  = grp_par;
          finish  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
      if (accept) begin
        a_q <= bus.a;
        b_q <= bus.b;
        n_q <= bus.n;
      end
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

`ifdef GEN_LINEAR_SELFCHECK_EN
  logic          err_q, err_d;
  logic [NBIT:0] ref_sum;

  always_comb begin
    ref_sum = {1'b0, a_q} + {1'b0, b_q};
    err_d   = err_q;
    if (accept)      err_d = 1'b0;
    else if (finish) err_d = ({cout_d, sum_d} != ref_sum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
